// File: rtl/mcdf_arbiter.sv
// Three-slave round-robin packet arbiter for the MCDF formatter.
// Latches one channel, handshakes with the formatter, then forwards that slave's packet with length checking.
module mcdf_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              slv0_req_i,
  input  logic              slv0_val_i,
  input  logic [DATA_W-1:0] slv0_data_i,
  input  logic              slv0_end_i,
  input  logic [2:0]        slv0_pkglen_i,
  input  logic              slv1_req_i,
  input  logic              slv1_val_i,
  input  logic [DATA_W-1:0] slv1_data_i,
  input  logic              slv1_end_i,
  input  logic [2:0]        slv1_pkglen_i,
  input  logic              slv2_req_i,
  input  logic              slv2_val_i,
  input  logic [DATA_W-1:0] slv2_data_i,
  input  logic              slv2_end_i,
  input  logic [2:0]        slv2_pkglen_i,
  output logic              a2s0_ack_o,
  output logic              a2s1_ack_o,
  output logic              a2s2_ack_o,
  output logic              fmt_req_o,
  input  logic              fmt_grant_i,
  output logic [1:0]        fmt_id_o,
  output logic [5:0]        fmt_length_o,
  output logic              fmt_val_o,
  output logic              fmt_end_o,
  output logic [DATA_W-1:0] fmt_data_o,
  output logic              err_o
);

  localparam int unsigned NCH   = 3;
  localparam int unsigned NSLOT = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned LEN_W = 6;
  localparam int unsigned PKG_W = 3;

  typedef enum logic [1:0] {IDLE, REQ, ACK, XFER} state_t;

  state_t state, state_next;

  // Slave buses gathered into arrays; slot 3 is a dead channel so a 2-bit id always indexes in range.
  logic [NSLOT-1:0] req, val, endw;
  logic [DATA_W-1:0] data [NSLOT];
  logic [PKG_W-1:0]  pkglen [NSLOT];

  assign req = {1'b0, slv2_req_i, slv1_req_i, slv0_req_i};
  assign val = {1'b0, slv2_val_i, slv1_val_i, slv0_val_i};
  assign endw = {1'b0, slv2_end_i, slv1_end_i, slv0_end_i};
  assign data[0] = slv0_data_i;
  assign data[1] = slv1_data_i;
  assign data[2] = slv2_data_i;
  assign data[3] = '0;
  assign pkglen[0] = slv0_pkglen_i;
  assign pkglen[1] = slv1_pkglen_i;
  assign pkglen[2] = slv2_pkglen_i;
  assign pkglen[3] = '0;

  logic [ID_W-1:0]   ptr_q, ptr_n;
  logic [LEN_W-1:0]  cnt_q, cnt_n;
  logic [ID_W-1:0]   id_n;
  logic [LEN_W-1:0]  len_n;
  logic [NCH-1:0]    ack_q, ack_n;
  logic              req_n, val_n, end_n, err_n;
  logic [DATA_W-1:0] data_n;

  logic [ID_W-1:0] rr_id, rr_cand;
  logic            rr_found;
  logic            word_last, word_end;

  function automatic logic [LEN_W-1:0] decode_len(input logic [PKG_W-1:0] code);
    case (code)
      3'd0:    return LEN_W'(4);
      3'd1:    return LEN_W'(8);
      3'd2:    return LEN_W'(16);
      default: return LEN_W'(32);
    endcase
  endfunction

  // Round-robin search starting one past the last served channel.
  always_comb begin
    rr_id    = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= int'(NCH); i++) begin
      rr_cand = ID_W'((int'(ptr_q) + i) % int'(NCH));
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_id    = rr_cand;
      end
    end
  end

  assign word_last = (cnt_q == LEN_W'(fmt_length_o - LEN_W'(1)));
  assign word_end  = endw[fmt_id_o] | word_last;

  always_comb begin
    state_next = state;
    id_n       = fmt_id_o;
    len_n      = fmt_length_o;
    ptr_n      = ptr_q;
    cnt_n      = cnt_q;
    req_n      = 1'b0;
    ack_n      = '0;
    val_n      = 1'b0;
    end_n      = 1'b0;
    err_n      = 1'b0;
    data_n     = fmt_data_o;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next = REQ;
          id_n       = rr_id;
          len_n      = decode_len(pkglen[rr_id]);
          req_n      = 1'b1;
        end
      end
      REQ: begin
        req_n = 1'b1;
        if (fmt_grant_i) begin
          state_next = ACK;
          req_n      = 1'b0;
          ack_n      = NCH'(3'b001 << fmt_id_o);
        end
      end
      ACK: begin
        state_next = XFER;
        cnt_n      = '0;
      end
      XFER: begin
        if (val[fmt_id_o]) begin
          val_n  = 1'b1;
          data_n = data[fmt_id_o];
          end_n  = word_end;
          // Error when the slave's end flag and the decoded length disagree.
          err_n  = endw[fmt_id_o] ^ word_last;
          cnt_n  = LEN_W'(cnt_q + LEN_W'(1));
          if (word_end) begin
            state_next = IDLE;
            ptr_n      = fmt_id_o;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q        <= ID_W'(2);
      cnt_q        <= '0;
      fmt_id_o     <= '0;
      fmt_length_o <= '0;
      fmt_req_o    <= 1'b0;
      ack_q        <= '0;
      fmt_val_o    <= 1'b0;
      fmt_end_o    <= 1'b0;
      err_o        <= 1'b0;
      fmt_data_o   <= '0;
    end else begin
      ptr_q        <= ptr_n;
      cnt_q        <= cnt_n;
      fmt_id_o     <= id_n;
      fmt_length_o <= len_n;
      fmt_req_o    <= req_n;
      ack_q        <= ack_n;
      fmt_val_o    <= val_n;
      fmt_end_o    <= end_n;
      err_o        <= err_n;
      fmt_data_o   <= data_n;
    end
  end

  assign a2s0_ack_o = ack_q[0];
  assign a2s1_ack_o = ack_q[1];
  assign a2s2_ack_o = ack_q[2];

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: slave driver tasks push expected formatter words,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_mcdf_arbiter;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req = '0, val = '0, endw = '0;
  logic [DW-1:0] data [3];
  logic [2:0]    pkglen [3];
  logic          grant = 1'b0;

  wire [2:0]     ack;
  logic          fmt_req, fmt_val, fmt_end, err;
  logic [1:0]    fmt_id;
  logic [5:0]    fmt_length;
  logic [DW-1:0] fmt_data;

  mcdf_arbiter #(.DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv0_req_i(req[0]), .slv0_val_i(val[0]), .slv0_data_i(data[0]),
    .slv0_end_i(endw[0]), .slv0_pkglen_i(pkglen[0]),
    .slv1_req_i(req[1]), .slv1_val_i(val[1]), .slv1_data_i(data[1]),
    .slv1_end_i(endw[1]), .slv1_pkglen_i(pkglen[1]),
    .slv2_req_i(req[2]), .slv2_val_i(val[2]), .slv2_data_i(data[2]),
    .slv2_end_i(endw[2]), .slv2_pkglen_i(pkglen[2]),
    .a2s0_ack_o(ack[0]), .a2s1_ack_o(ack[1]), .a2s2_ack_o(ack[2]),
    .fmt_req_o(fmt_req), .fmt_grant_i(grant),
    .fmt_id_o(fmt_id), .fmt_length_o(fmt_length),
    .fmt_val_o(fmt_val), .fmt_end_o(fmt_end), .fmt_data_o(fmt_data),
    .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    logic          r;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int total = 0, bad = 0, cyc = 0;
  int n_val = 0, n_err = 0, n_ack = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every forwarded word must match the head of the scoreboard, one cycle after drive.
  always @(negedge clk) begin
    if (!rst) begin
      if (fmt_val) begin
        n_val++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word act data=%h end=%b err=%b exp none", fmt_data, fmt_end, err);
        end else begin
          mx = q.pop_front();
          if (fmt_data !== mx.d || fmt_end !== mx.e || err !== mx.r || cyc != mx.cyc) begin
            bad++;
            $display("FAIL word act data=%h end=%b err=%b cyc=%0d exp data=%h end=%b err=%b cyc=%0d",
                     fmt_data, fmt_end, err, cyc, mx.d, mx.e, mx.r, mx.cyc);
          end
        end
      end else if (err) begin
        total++;
        bad++;
        $display("FAIL err_without_word act err=1 exp err=0");
      end
      if (err) n_err++;
      if (ack != 3'b000) begin
        total++;
        if ($countones(ack) != 1) begin
          bad++;
          $display("FAIL onehot_ack act=%b exp one bit", ack);
        end
        n_ack += $countones(ack);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(output int ch);
    ch = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        ch = ack[0] ? 0 : (ack[1] ? 1 : 2);
        break;
      end
    end
  endtask

  // Drive up to nmax words from slave ch; end flag on word end_at; stop once the DUT must close the packet.
  task automatic send_pkt(input int ch, input int len, input int end_at, input int nmax,
                          input bit gap, input int tag);
    @(posedge clk); #1;
    for (int i = 0; i < nmax; i++) begin
      bit e_exp, r_exp;
      logic [DW-1:0] w;
      e_exp = (i == end_at) || (i == len - 1);
      r_exp = e_exp && !((i == end_at) && (i == len - 1));
      w = 32'hA000_0000 | (32'(ch) << 16) | (32'(tag) << 8) | 32'(i);
      if (gap && (i % 3 == 1)) begin
        @(posedge clk); #1;
      end
      val[ch]  = 1'b1;
      data[ch] = w;
      endw[ch] = (i == end_at);
      q.push_back('{d: w, e: e_exp, r: r_exp, cyc: cyc + 1});
      @(posedge clk); #1;
      val[ch]  = 1'b0;
      endw[ch] = 1'b0;
      if (e_exp) break;
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_fmt_req"}, 32'(fmt_req), 0);
    chk({pfx, "_fmt_id"}, 32'(fmt_id), 0);
    chk({pfx, "_fmt_length"}, 32'(fmt_length), 0);
    chk({pfx, "_fmt_val"}, 32'(fmt_val), 0);
    chk({pfx, "_fmt_end"}, 32'(fmt_end), 0);
    chk({pfx, "_fmt_data"}, fmt_data, 0);
    chk({pfx, "_err"}, 32'(err), 0);
    chk({pfx, "_ack"}, 32'(ack), 0);
  endtask

  initial begin
    int ch, a0, v0, e0, nreq;
    int order [4];
    order = '{0, 1, 2, 0};
    for (int i = 0; i < 3; i++) begin
      data[i]   = '0;
      pkglen[i] = '0;
    end

    #12;
    chk_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // All slaves requesting, grant tied high: ch0, ch1, ch2, ch0.
    a0 = n_ack;
    grant = 1'b1;
    req = 3'b111;
    for (int p = 0; p < 4; p++) begin
      wait_ack(ch);
      chk("rr_order", 32'(ch), 32'(order[p]));
      chk("rr_length", 32'(fmt_length), 4);
      if (ch >= 0) send_pkt(ch, 4, 3, 4, 1'b0, p);
    end
    req = 3'b000;
    repeat (4) @(negedge clk);
    chk("rr_ack_count", 32'(n_ack - a0), 4);

    // Slave 1 alone, pkglen 2, grant delayed; req drops while waiting in REQ.
    grant = 1'b0;
    pkglen[1] = 3'd2;
    a0 = n_ack;
    req[1] = 1'b1;
    for (int n = 0; n < 20 && !fmt_req; n++) @(negedge clk);
    chk("dly_req_seen", 32'(fmt_req), 1);
    chk("dly_id", 32'(fmt_id), 1);
    chk("dly_length", 32'(fmt_length), 16);
    nreq = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) req[1] = 1'b0;
      nreq += int'(fmt_req);
    end
    chk("dly_no_early_ack", 32'(n_ack - a0), 0);
    chk("dly_req_cycles", 32'(nreq), 5);
    grant = 1'b1;
    wait_ack(ch);
    grant = 1'b0;
    chk("dly_ack_ch", 32'(ch), 1);
    chk("dly_req_low_in_ack", 32'(fmt_req), 0);
    if (ch >= 0) send_pkt(1, 16, 15, 16, 1'b0, 9);
    repeat (3) @(negedge clk);
    chk("dly_ack_count", 32'(n_ack - a0), 1);

    // Grant with nobody requesting is ignored.
    grant = 1'b1;
    a0 = n_ack;
    repeat (4) @(negedge clk);
    chk("idle_grant_req", 32'(fmt_req), 0);
    chk("idle_grant_ack", 32'(n_ack - a0), 0);

    // Slave 2, 8 words with gaps; slave 0 noise on its val/data must be ignored.
    pkglen[2] = 3'd1;
    v0 = n_val; e0 = n_err;
    val[0] = 1'b1;
    data[0] = 32'hDEAD_BEEF;
    req[2] = 1'b1;
    wait_ack(ch);
    req[2] = 1'b0;
    chk("gap_ack_ch", 32'(ch), 2);
    chk("gap_length", 32'(fmt_length), 8);
    if (ch >= 0) send_pkt(2, 8, 7, 8, 1'b1, 3);
    val[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("gap_val_count", 32'(n_val - v0), 8);
    chk("gap_err_count", 32'(n_err - e0), 0);

    // Early end on word 2 of a 4-word packet, then a stray word that must be dropped.
    pkglen[0] = 3'd0;
    v0 = n_val; e0 = n_err;
    req[0] = 1'b1;
    wait_ack(ch);
    req[0] = 1'b0;
    chk("early_ack_ch", 32'(ch), 0);
    if (ch >= 0) send_pkt(0, 4, 1, 4, 1'b0, 4);
    val[0] = 1'b1;
    data[0] = 32'h5555_0000;
    @(posedge clk); #1;
    val[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("early_val_count", 32'(n_val - v0), 2);
    chk("early_err_count", 32'(n_err - e0), 1);
    chk("early_idle_req", 32'(fmt_req), 0);

    // Missing end: fourth word is forced to end with an error.
    v0 = n_val; e0 = n_err;
    req[0] = 1'b1;
    wait_ack(ch);
    req[0] = 1'b0;
    chk("noend_ack_ch", 32'(ch), 1'b0);
    if (ch >= 0) send_pkt(0, 4, 99, 4, 1'b0, 5);
    repeat (3) @(negedge clk);
    chk("noend_val_count", 32'(n_val - v0), 4);
    chk("noend_err_count", 32'(n_err - e0), 1);

    // Reset in the middle of a channel 1 transfer.
    pkglen[1] = 3'd1;
    req[1] = 1'b1;
    wait_ack(ch);
    req[1] = 1'b0;
    chk("rst_ack_ch", 32'(ch), 1);
    e0 = n_err;
    if (ch >= 0) send_pkt(1, 8, 7, 3, 1'b0, 6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_zero("midrst");
    chk("midrst_err_count", 32'(n_err - e0), 0);
    req = 3'b111;
    pkglen[0] = 3'd0; pkglen[1] = 3'd0; pkglen[2] = 3'd0;
    grant = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    wait_ack(ch);
    req = 3'b000;
    chk("post_rst_ack_ch", 32'(ch), 0);
    if (ch >= 0) send_pkt(0, 4, 3, 4, 1'b0, 7);
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcdf_arbiter.md
MCDF_ARBITER -- requirements
Module: mcdf_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, data width of slave and formatter data buses.
REQ-002 Ports: clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 Ports: rst_i  input  1  asynchronous, active-high reset.
REQ-004 Ports: slvN_req_i  input  1  (N=0..2) slave N holds at least one full packet.
REQ-005 Ports: slvN_val_i  input  1  slave N data word valid.
REQ-006 Ports: slvN_data_i  input  DATA_W  slave N data word.
REQ-007 Ports: slvN_end_i  input  1  slave N last word of packet.
REQ-008 Ports: slvN_pkglen_i  input  3  slave N packet-length code.
REQ-009 Ports: a2sN_ack_o  output  1  one-cycle grant pulse to slave N.
REQ-010 Ports: fmt_req_o, fmt_grant_i  output/input  1  formatter request/grant handshake.
REQ-011 Ports: fmt_id_o  output  2  served channel; fmt_length_o  output  6  packet length in words.
REQ-012 Ports: fmt_val_o, fmt_end_o  output  1; fmt_data_o  output  DATA_W  forwarded packet stream.
REQ-013 Ports: err_o  output  1  one-cycle packet-length error pulse.

Function
REQ-014 Length decode SHALL be: code 0->4, 1->8, 2->16, 3..7->32 words.
REQ-015 FSM SHALL have states IDLE, REQ, ACK, XFER; reset state IDLE.
REQ-016 IDLE: if any slvN_req_i high, SHALL select one channel by round-robin, latch id and decoded length, go to REQ next cycle.
REQ-017 Round-robin: search SHALL start at (last served + 1) mod 3; last-served pointer resets to 2, so channel 0 has first priority after reset.
REQ-018 REQ: fmt_req_o SHALL be high with fmt_id_o/fmt_length_o stable; on fmt_grant_i high go to ACK.
REQ-019 Latched channel SHALL be kept even if its slvN_req_i drops during REQ.
REQ-020 ACK: a2sN_ack_o of latched channel SHALL be high for exactly one cycle; fmt_req_o low; go to XFER.
REQ-021 At most one a2sN_ack_o SHALL be high in any cycle.
REQ-022 XFER: every cycle latched slvN_val_i is high, slvN_data_i/slvN_end_i SHALL appear registered on fmt_data_o/fmt_end_o with fmt_val_o=1 one cycle later (latency 1); non-latched slaves ignored.
REQ-023 fmt_val_o SHALL be 0 in cycles with no accepted word; fmt_data_o holds last value.
REQ-024 A 6-bit word counter SHALL clear on entering XFER and increment per accepted word.
REQ-025 Normal end: word with slvN_end_i=1 at count==length-1 SHALL end packet; update last-served pointer; return to IDLE.
REQ-026 Early end (end at count<length-1) or missing end (count reaches length-1 without end): SHALL forward that word with fmt_end_o=1, pulse err_o same cycle, return to IDLE.
REQ-027 From IDLE, arbitration for the next packet SHALL begin the cycle after return (no back-to-back ack within 3 cycles).
REQ-028 fmt_grant_i outside REQ SHALL be ignored.

Reset
REQ-029 On rst_i high, asynchronously: state IDLE, all outputs 0 (fmt_data_o=0, fmt_id_o=0, fmt_length_o=0), counter 0, pointer 2.
REQ-030 Reset mid-XFER SHALL abort the packet without err_o; after release arbitration restarts from channel 0.

Verification
REQ-031 slv0_req=slv1_req=slv2_req=1, pkglen=0, grant tied high -> packets served ch0,ch1,ch2,ch0; one ack pulse each; fmt_length_o=4.
REQ-032 Only slv1_req=1, pkglen=2, grant delayed 5 cycles -> fmt_req_o high 5 cycles, fmt_id_o=1, fmt_length_o=16, a2s1_ack_o pulses once after grant.
REQ-033 Slave 2 sends 8 words with val gaps, end on word 8 -> fmt_val_o exactly 8 pulses, each 1 cycle after input, fmt_end_o on 8th, err_o never high.
REQ-034 pkglen=0, slave asserts end on word 2 -> fmt_end_o and err_o on 2nd forwarded word; state IDLE next cycle.
REQ-035 pkglen=0, slave omits end -> 4th word forwarded with fmt_end_o=1, err_o pulse.
REQ-036 rst_i asserted mid-XFER of ch1 packet -> all outputs 0 immediately, no err_o; after release with all reqs high, ch0 acked first.
